// File: rtl/sc_hdlc_upload_arbiter.sv
// Round-robin arbiter sharing one HDLC TX AXI-Stream path between N_CH upload sources.
// A granted channel owns the framer path until its tlast beat or an idle timeout.
module sc_hdlc_upload_arbiter #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_CH-1:0]         upload_req,
    input  logic [N_CH*DW-1:0]      s_axis_tdata,
    input  logic [N_CH-1:0]         s_axis_tvalid,
    input  logic [N_CH-1:0]         s_axis_tlast,
    output logic [N_CH-1:0]         s_axis_tready,
    output logic [DW-1:0]           m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [$clog2(N_CH)-1:0] grant_id,
    output logic                    busy,
    output logic [N_CH-1:0]         done,
    output logic                    abort
);

    localparam int unsigned GW = $clog2(N_CH);
    localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]   TO_LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [GW-1:0]   LAST_CH = GW'(N_CH - 1);
    localparam logic [N_CH-1:0] ONE     = N_CH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t          state, state_d;
    logic [N_CH-1:0] pending, pending_d;
    logic [GW-1:0]   rr_ptr, rr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   idle_cnt, cnt_d;
    logic [N_CH-1:0] done_q, done_d;
    logic            abort_q, abort_d;

    logic [GW-1:0]   sel_ch;
    logic [GW-1:0]   cand;
    logic            sel_vld;
    logic [DW-1:0]   cur_data;
    logic            cur_valid;
    logic            cur_last;
    logic            hs;
    logic            in_xfer;
    logic [GW-1:0]   rr_next;

    // First pending channel scanning upward from rr_ptr with wrap
    always_comb begin
        sel_ch  = '0;
        sel_vld = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cand = GW'((32'(rr_ptr) + i) % N_CH);
            if (!sel_vld && pending[cand]) begin
                sel_vld = 1'b1;
                sel_ch  = cand;
            end
        end
    end

    // Granted channel's stream signals
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant_q == GW'(i)) begin
                cur_data  = s_axis_tdata[i*DW +: DW];
                cur_valid = s_axis_tvalid[i];
                cur_last  = s_axis_tlast[i];
            end
        end
    end

    assign in_xfer = rstn && (state == S_XFER);
    assign hs      = in_xfer && cur_valid && m_axis_tready;
    assign rr_next = (grant_q == LAST_CH) ? '0 : GW'(grant_q + 1'b1);

    // Next-state, request latching, pointer and timeout bookkeeping
    always_comb begin
        state_d   = state;
        pending_d = pending | upload_req;
        rr_d      = rr_ptr;
        grant_d   = grant_q;
        cnt_d     = idle_cnt;
        done_d    = '0;
        abort_d   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (sel_vld) begin
                    grant_d   = sel_ch;
                    pending_d = (pending & ~(ONE << sel_ch)) | upload_req;
                    cnt_d     = '0;
                    state_d   = S_XFER;
                end
            end
            S_XFER: begin
                if (hs) begin
                    cnt_d = '0;
                    if (cur_last) begin
                        done_d[grant_q] = 1'b1;
                        state_d         = S_DONE;
                    end
                end else if ((TIMEOUT_CYC != 0) && (idle_cnt == TO_LAST)) begin
                    abort_d = 1'b1;
                    rr_d    = rr_next;
                    state_d = S_IDLE;
                end else if (idle_cnt != '1) begin
                    cnt_d = idle_cnt + 1'b1;
                end
            end
            S_DONE: begin
                rr_d    = rr_next;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            pending  <= '0;
            rr_ptr   <= '0;
            grant_q  <= '0;
            idle_cnt <= '0;
            done_q   <= '0;
            abort_q  <= 1'b0;
        end else begin
            state    <= state_d;
            pending  <= pending_d;
            rr_ptr   <= rr_d;
            grant_q  <= grant_d;
            idle_cnt <= cnt_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    assign m_axis_tdata  = in_xfer ? cur_data : '0;
    assign m_axis_tvalid = in_xfer && cur_valid;
    assign m_axis_tlast  = in_xfer && cur_last;
    assign s_axis_tready = (in_xfer && m_axis_tready) ? (ONE << grant_q) : '0;
    assign grant_id      = grant_q;
    assign busy          = in_xfer;
    assign done          = rstn ? done_q : '0;
    assign abort         = rstn && abort_q;

endmodule

// File: tb/tb_sc_hdlc_upload_arbiter.sv
// Self-checking bench for sc_hdlc_upload_arbiter with a frame-level reference model.
module tb_sc_hdlc_upload_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  upload_req;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]  s_tvalid;
    logic [N-1:0]  s_tlast;
    logic [N-1:0]  s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [1:0]    grant_id;
    logic          busy;
    logic [N-1:0]  done;
    logic          abort;

    sc_hdlc_upload_arbiter #(.N_CH(N), .DW(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn), .upload_req(upload_req),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready), .grant_id(grant_id),
        .busy(busy), .done(done), .abort(abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit tog = 0;

    // Source agents: endless frames of src_len beats, optional stall after src_stall beats
    int src_len[N], src_base[N], src_idx[N], src_frame[N], src_stall[N];
    bit src_hs[N];

    // Reference model: frame-level view of the arbiter
    bit mp[N];
    int mptr = 0, mch = 0, mgid = 0, mgap = 0, mstall = 0, mdone = -1;
    bit mbusy = 0, mabort = 0;
    bit mhs;

    // Event logs for literal expectations
    int n_grants = 0, n_done = 0, n_abort = 0, n_beats = 0;
    int glog[$], glog_cyc[$], dlog_cyc[$];
    logic [N-1:0] dlog_val[$];
    logic [7:0] flog[$];
    int last_hs_edge = 0, abort_cyc = 0, ab_gap = 0;
    bit pbusy = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit src_v(input int ch);
        return (src_len[ch] > 0) && (src_idx[ch] < src_len[ch]) &&
               ((src_stall[ch] < 0) || (src_idx[ch] < src_stall[ch]));
    endfunction

    task automatic drive_src();
        for (int ch = 0; ch < N; ch++) begin
            s_tvalid[ch] = src_v(ch);
            s_tlast[ch]  = (src_len[ch] > 0) && (src_idx[ch] == src_len[ch] - 1);
            s_tdata[ch*DW +: DW] = (src_len[ch] > 0) ?
                8'(src_base[ch] + src_frame[ch] * 16 + src_idx[ch]) : 8'h00;
        end
    endtask

    task automatic set_src(input int ch, input int len, input int base, input int stall);
        src_len[ch] = len; src_base[ch] = base; src_idx[ch] = 0;
        src_frame[ch] = 0; src_stall[ch] = stall;
        drive_src();
    endtask

    function automatic int rr_pick();
        for (int k = 0; k < N; k++)
            if (mp[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    // Model update at each edge, then source agents and tready pattern advance
    always @(posedge clk) begin
        mhs = rstn && mbusy && s_tvalid[mch] && m_tready;
        for (int ch = 0; ch < N; ch++) src_hs[ch] = mhs && (ch == mch);
        if (!rstn) begin
            for (int ch = 0; ch < N; ch++) mp[ch] = 0;
            mptr = 0; mch = 0; mgid = 0; mgap = 0; mstall = 0;
            mdone = -1; mbusy = 0; mabort = 0;
        end else begin
            mdone = -1; mabort = 0;
            if (mbusy) begin
                if (mhs) begin
                    mstall = 0;
                    if (s_tlast[mch]) begin
                        mbusy = 0; mdone = mch; mgap = 1; mptr = (mch + 1) % N;
                    end
                end else if (mstall == TO - 1) begin
                    mbusy = 0; mabort = 1; mptr = (mch + 1) % N;
                end else begin
                    mstall++;
                end
            end else if (mgap > 0) begin
                mgap--;
            end else if (rr_pick() >= 0) begin
                mch = rr_pick(); mgid = mch; mbusy = 1; mstall = 0; mp[mch] = 0;
            end
            for (int ch = 0; ch < N; ch++) if (upload_req[ch]) mp[ch] = 1;
        end
        cyc++;
        #2;
        for (int ch = 0; ch < N; ch++) begin
            if (src_hs[ch]) begin
                if (src_idx[ch] == src_len[ch] - 1) begin
                    src_idx[ch] = 0; src_frame[ch]++;
                end else begin
                    src_idx[ch]++;
                end
            end
        end
        m_tready = tog ? ~m_tready : 1'b1;
        drive_src();
    end

    // Compare all outputs against the model every cycle, and log events
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rstn) begin
                chk("busy", 32'(busy), 0);
                chk("m_tvalid", 32'(m_tvalid), 0);
                chk("m_tlast", 32'(m_tlast), 0);
                chk("m_tdata", 32'(m_tdata), 0);
                chk("s_tready", 32'(s_tready), 0);
                chk("done", 32'(done), 0);
                chk("abort", 32'(abort), 0);
            end else begin
                chk("busy", 32'(busy), 32'(mbusy));
                chk("grant_id", 32'(grant_id), 32'(mgid));
                chk("m_tvalid", 32'(m_tvalid), 32'(mbusy && s_tvalid[mch]));
                chk("m_tlast", 32'(m_tlast), 32'(mbusy && s_tlast[mch]));
                chk("m_tdata", 32'(m_tdata), mbusy ? 32'(s_tdata[mch*DW +: DW]) : 0);
                chk("s_tready", 32'(s_tready), (mbusy && m_tready) ? (32'(1) << mch) : 0);
                chk("done", 32'(done), (mdone >= 0) ? (32'(1) << mdone) : 0);
                chk("abort", 32'(abort), 32'(mabort));
            end
        end
        if (busy && !pbusy) begin
            n_grants++; glog.push_back(int'(grant_id)); glog_cyc.push_back(cyc);
        end
        pbusy = busy;
        if (|done) begin
            n_done++; dlog_cyc.push_back(cyc); dlog_val.push_back(done);
        end
        if (abort) begin
            n_abort++; abort_cyc = cyc; ab_gap = cyc - last_hs_edge;
        end
        if (m_tvalid && m_tready) begin
            n_beats++; flog.push_back(m_tdata); last_hs_edge = cyc + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic req(input logic [N-1:0] mask);
        upload_req = mask;
        step(1);
        upload_req = '0;
    endtask

    task automatic wait_evt(input string nm, input int which, input int target, input int budget);
        bit ok;
        int n;
        ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            #1;
            n = (which == 0) ? n_grants : (which == 1) ? n_done : n_abort;
            if (n >= target) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: event count never reached %0d within %0d cycles", nm, target, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, d0, a0, b0, rq;
        rstn = 1'b0; upload_req = '0; m_tready = 1'b1; s_tdata = '0;
        s_tvalid = '0; s_tlast = '0;
        for (int ch = 0; ch < N; ch++) set_src(ch, 0, 0, -1);
        step(1);
        chk_en = 1;
        step(2);
        rstn = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_done", 32'(done), 0);
        step(2);

        // T2: ch1 and ch3 together from rr_ptr=0
        set_src(1, 2, 'h10, -1); set_src(3, 2, 'h30, -1);
        g0 = n_grants; d0 = n_done;
        req(4'b1010);
        wait_evt("t2_done", 1, d0 + 2, 60);
        chk("t2_first", 32'(glog[g0]), 1);
        chk("t2_second", 32'(glog[g0+1]), 3);
        chk("t2_gap", 32'(glog_cyc[g0+1] - dlog_cyc[d0]), 2);
        // rr_ptr back at 0: ch0 wins over ch1
        set_src(0, 1, 'h00, -1);
        req(4'b0011);
        wait_evt("t2b_done", 1, d0 + 4, 60);
        chk("t2b_first", 32'(glog[g0+2]), 0);
        chk("t2b_second", 32'(glog[g0+3]), 1);
        step(3);

        // T1: single req on ch2, 3-beat frame
        set_src(2, 3, 'h20, -1);
        g0 = n_grants; d0 = n_done; b0 = n_beats; rq = cyc;
        req(4'b0100);
        wait_evt("t1_done", 1, d0 + 1, 40);
        chk("t1_grant", 32'(glog[g0]), 2);
        chk("t1_latency", 32'(glog_cyc[g0] - rq), 2);
        chk("t1_done_val", 32'(dlog_val[d0]), 32'h4);
        chk("t1_frame_len", 32'(dlog_cyc[d0] - glog_cyc[g0]), 3);
        chk("t1_beats", 32'(n_beats - b0), 3);
        chk("t1_b0", 32'(flog[b0]), 32'h20);
        chk("t1_b2", 32'(flog[b0+2]), 32'h22);
        step(3);

        // T3: ch0 keeps re-requesting while ch2 waits
        set_src(0, 2, 'h40, -1); set_src(2, 2, 'h50, -1);
        g0 = n_grants; d0 = n_done;
        req(4'b0101);
        for (int k = 0; k < 3; k++) begin
            wait_evt("t3_grant", 0, g0 + k + 1, 40);
            req(4'b0101);
        end
        wait_evt("t3_done", 1, d0 + 5, 100);
        chk("t3_g0", 32'(glog[g0]), 0);
        chk("t3_g1", 32'(glog[g0+1]), 2);
        chk("t3_g2", 32'(glog[g0+2]), 0);
        chk("t3_g3", 32'(glog[g0+3]), 2);
        chk("t3_g4", 32'(glog[g0+4]), 0);
        step(3);

        // T4: tready toggling, 5-beat frame on ch1
        set_src(1, 5, 'hA0, -1);
        d0 = n_done; b0 = flog.size();
        tog = 1;
        req(4'b0010);
        wait_evt("t4_done", 1, d0 + 1, 60);
        tog = 0;
        chk("t4_beats", 32'(flog.size() - b0), 5);
        for (int k = 0; k < 5; k++) chk("t4_order", 32'(flog[b0+k]), 32'('hA0 + k));
        step(3);

        // T5: ch3 stalls after 2 beats, ch0 waiting behind it
        set_src(3, 6, 'hC0, 2); set_src(0, 1, 'h60, -1);
        g0 = n_grants; d0 = n_done; a0 = n_abort; b0 = flog.size();
        req(4'b1001);
        wait_evt("t5_abort", 2, a0 + 1, 80);
        chk("t5_abort_gap", 32'(ab_gap), 16);
        chk("t5_no_done", 32'(n_done), 32'(d0));
        chk("t5_beats", 32'(flog.size() - b0), 2);
        wait_evt("t5_next", 1, d0 + 1, 40);
        chk("t5_first", 32'(glog[g0]), 3);
        chk("t5_next_ch", 32'(glog[g0+1]), 0);
        chk("t5_regrant", 32'(glog_cyc[g0+1] - abort_cyc), 1);
        set_src(3, 0, 0, -1);
        step(3);

        // T6: reset mid-frame with ch1 and ch2 pending
        set_src(1, 8, 'h70, -1); set_src(2, 2, 'h80, -1);
        g0 = n_grants;
        req(4'b0110);
        wait_evt("t6_grant", 0, g0 + 1, 20);
        req(4'b0110);
        rstn = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_m_tvalid", 32'(m_tvalid), 0);
        chk("t6_s_tready", 32'(s_tready), 0);
        step(1);
        rstn = 1'b1;
        step(10);
        chk("t6_no_grant", 32'(n_grants), 32'(g0 + 1));
        chk("t6_idle", 32'(busy), 0);
        g0 = n_grants;
        req(4'b0100);
        wait_evt("t6_regrant", 0, g0 + 1, 20);
        chk("t6_new_ch", 32'(glog[g0]), 2);
        step(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
